hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline control block for the 5-stage MIPS datapath.
- Sits directly upstream of the PC and inter-stage pipeline registers; drives their `enable` and `clear` inputs every cycle.
- Resolves load-use stalls, branch/jump flushes and the halt (syscall) drain sequence.
- Keeps cycle, stall and flush statistics for the board display.

Parameters:
DRAIN_CYCLES, 3, cycles spent draining older instructions after a halt request before freezing
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  system clock, all state updates on posedge
clear  input  1  synchronous active-high reset
run  input  1  1 = pipeline advances; 0 = pause (board switch)
idex_mem_read  input  1  instruction in ID/EX is a load
idex_rt  input  5  destination register of that load
ifid_rs  input  5  rs field of instruction in IF/ID
ifid_rt  input  5  rt field of instruction in IF/ID
ifid_uses_rs  input  1  IF/ID instruction reads rs
ifid_uses_rt  input  1  IF/ID instruction reads rt
jump  input  1  jump decoded in ID
branch_taken  input  1  branch resolved taken in EX
halt_req  input  1  halting syscall in EX
pc_en  output  1  enable for PC register
ifid_en  output  1  enable for IF/ID register
ifid_clear  output  1  clear for IF/ID register
idex_en  output  1  enable for ID/EX register
idex_clear  output  1  clear for ID/EX register
exmem_en  output  1  enable for EX/MEM register
memwb_en  output  1  enable for MEM/WB register
halted  output  1  1 once pipeline is frozen
cycle_cnt  output  CNT_W  cycles advanced
stall_cnt  output  CNT_W  load-use stall cycles
flush_cnt  output  CNT_W  flush cycles

Behaviour:
- Interface: one clock `clk`; reset `clear` is synchronous and active-high.
- Register contents: registered state is FSM state, drain counter and the three statistics counters.
- Output timing: all enable/clear outputs are combinational from current state and inputs, valid in the same cycle.

Reset:
- While `clear`=1:
  - ifid_clear=1, idex_clear=1.
  - All *_en=0.
  - Next state RUN, drain counter 0, halted=0, all counters 0.
- After reset, defaults in RUN with `run`=1 and no hazard: all *_en=1, all *_clear=0.

Hazard terms:
- `lu` (load-use) = idex_mem_read & idex_rt!=0 & ((ifid_uses_rs & ifid_rs==idex_rt) | (ifid_uses_rt & ifid_rt==idex_rt)).

RUN state, `run`=1, priority highest first:
1. halt_req:
   - pc_en=0, ifid_clear=1, idex_clear=1; exmem_en=memwb_en=1.
   - Load drain counter with DRAIN_CYCLES-1; go to DRAIN.
   - branch_taken, jump and lu are ignored this cycle.
2. branch_taken:
   - ifid_clear=1, idex_clear=1, pc_en=1; flush_cnt+1.
   - lu and jump are ignored.
3. lu:
   - pc_en=0, ifid_en=0, idex_clear=1; stall_cnt+1.
   - A jump in ID waits (no flush).
4. jump:
   - ifid_clear=1; flush_cnt+1.
5. None of the above: normal advance.
- Every `run`=1 cycle in RUN: cycle_cnt+1.

DRAIN state (`run`=1):
- pc_en=0, ifid_clear=1, idex_clear=1; exmem_en=memwb_en=1.
- Decrement drain counter each cycle; at 0, go to HALTED.
- cycle_cnt+1 per cycle.
- branch_taken, jump, halt_req and lu are ignored.

HALTED state:
- All *_en=0, *_clear=0, halted=1.
- Counters frozen; leaves only via `clear`.

Pause (`run`=0) in any state:
- All *_en=0, *_clear=0.
- State, drain counter and all counters hold.
- Hazard inputs are ignored; they are re-evaluated when `run` returns to 1.

Counters and boundaries:
- Counters wrap modulo 2^CNT_W without any flag.
- `clear` asserted mid-DRAIN or in HALTED returns to RUN on the next edge.
- idex_rt=0 never stalls.
- DRAIN_CYCLES=1: DRAIN lasts exactly one cycle.

Test Plan:
- Reset then 10 idle cycles with run=1 -> all *_en=1, clears 0, cycle_cnt=10, stall_cnt=0, flush_cnt=0.
- lw $5 in ID/EX (idex_mem_read=1, idex_rt=5), IF/ID add with ifid_rs=5, ifid_uses_rs=1 for one cycle -> pc_en=0, ifid_en=0, idex_clear=1 that cycle; stall_cnt=1.
- Same load with idex_rt=0 and ifid_rs=0 -> no stall, stall_cnt unchanged.
- branch_taken=1 together with lu and jump -> ifid_clear=1, idex_clear=1, pc_en=1; flush_cnt+1, stall_cnt unchanged.
- halt_req pulse at cycle 20 (DRAIN_CYCLES=3):
  - Cycles 20-23: pc_en=0 with exmem_en=1.
  - halted=1 from cycle 24; cycle_cnt frozen at 24.
  - Later branch_taken/halt_req have no effect.
- Sequence: run=0 for 5 cycles mid-stall, then clear=1 while HALTED.
  - During pause: all outputs 0 and counters hold.
  - After clear: halted=0, counters=0, state RUN next cycle.

Source files
------------

// File: rtl/hazard_stall_if.sv
// Bundle between the pipeline control block and the datapath it steers.
// Signalling contract: there is no valid/ready handshake here. Every input
// is a level that is sampled on each posedge clk. Every enable/clear output
// is a level that is valid within the same cycle. The statistics counters
// and dbg_state are registered.
interface hazard_stall_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             idex_mem_read;
  logic [4:0]       idex_rt;
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rs;
  logic             ifid_uses_rt;
  logic             jump;
  logic             branch_taken;
  logic             halt_req;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_clear;
  logic             idex_en;
  logic             idex_clear;
  logic             exmem_en;
  logic             memwb_en;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       dbg_state;

  // Datapath side: supplies decode/hazard information and consumes controls.
  modport master (
    output run, idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rs,
           ifid_uses_rt, jump, branch_taken, halt_req,
    input  pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en,
           memwb_en, halted, cycle_cnt, stall_cnt, flush_cnt, dbg_state
  );

  // Controller side.
  modport slave (
    input  run, idex_mem_read, idex_rt, ifid_rs, ifid_rt, ifid_uses_rs,
           ifid_uses_rt, jump, branch_taken, halt_req,
    output pc_en, ifid_en, ifid_clear, idex_en, idex_clear, exmem_en,
           memwb_en, halted, cycle_cnt, stall_cnt, flush_cnt, dbg_state
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline control for the 5-stage MIPS datapath.
// - Load-use hazards stall the PC and IF/ID and insert a bubble into ID/EX.
// - A taken branch or a jump flushes the wrong-path instructions.
// - A halt request drains the older instructions and then freezes the pipeline.
// - Cycle, stall and flush statistics are kept for the board display.
module hazard_stall_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input logic           clk,
  input logic           clear,
  hazard_stall_if.slave bus
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    drain, drain_nxt;
  logic [CNT_W-1:0] cycle_q, stall_q, flush_q;
  logic             cyc_inc, stall_inc, flush_inc;
  logic             lu;

  assign lu = bus.idex_mem_read && (bus.idex_rt != 5'd0) &&
              ((bus.ifid_uses_rs && (bus.ifid_rs == bus.idex_rt)) ||
               (bus.ifid_uses_rt && (bus.ifid_rt == bus.idex_rt)));

  assign bus.cycle_cnt = cycle_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;
  assign bus.dbg_state = state;

  // State, drain counter and statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (clear) begin
      state   <= S_RUN;
      drain   <= '0;
      cycle_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state <= state_nxt;
      drain <= drain_nxt;
      if (cyc_inc)   cycle_q <= cycle_q + CNT_W'(1);
      if (stall_inc) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc) flush_q <= flush_q + CNT_W'(1);
    end
  end

  // Next-state and the per-cycle enable/clear controls.
  always_comb begin
    state_nxt      = state;
    drain_nxt      = drain;
    cyc_inc        = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;
    bus.pc_en      = 1'b0;
    bus.ifid_en    = 1'b0;
    bus.ifid_clear = 1'b0;
    bus.idex_en    = 1'b0;
    bus.idex_clear = 1'b0;
    bus.exmem_en   = 1'b0;
    bus.memwb_en   = 1'b0;
    bus.halted     = (state == S_HALTED);

    if (clear) begin
      // Flush both front registers while in reset. The registers above
      // perform the actual state reset.
      bus.ifid_clear = 1'b1;
      bus.idex_clear = 1'b1;
      bus.halted     = 1'b0;
    end else if (bus.run) begin
      case (state)
        S_RUN: begin
          cyc_inc      = 1'b1;
          bus.pc_en    = 1'b1;
          bus.ifid_en  = 1'b1;
          bus.idex_en  = 1'b1;
          bus.exmem_en = 1'b1;
          bus.memwb_en = 1'b1;
          if (bus.halt_req) begin
            // Stop fetching and squash the younger instructions. The older
            // instructions in EX/MEM/WB keep flowing out.
            bus.pc_en      = 1'b0;
            bus.ifid_clear = 1'b1;
            bus.idex_clear = 1'b1;
            drain_nxt      = DW'(DRAIN_CYCLES - 1);
            state_nxt      = S_DRAIN;
          end else if (bus.branch_taken) begin
            bus.ifid_clear = 1'b1;
            bus.idex_clear = 1'b1;
            flush_inc      = 1'b1;
          end else if (lu) begin
            // Hold the PC and IF/ID, and inject a bubble behind the load.
            // A jump waiting in ID is retried next cycle.
            bus.pc_en      = 1'b0;
            bus.ifid_en    = 1'b0;
            bus.idex_clear = 1'b1;
            stall_inc      = 1'b1;
          end else if (bus.jump) begin
            bus.ifid_clear = 1'b1;
            flush_inc      = 1'b1;
          end
        end
        S_DRAIN: begin
          cyc_inc        = 1'b1;
          bus.ifid_en    = 1'b1;
          bus.idex_en    = 1'b1;
          bus.ifid_clear = 1'b1;
          bus.idex_clear = 1'b1;
          bus.exmem_en   = 1'b1;
          bus.memwb_en   = 1'b1;
          if (drain == '0) begin
            state_nxt = S_HALTED;
          end else begin
            drain_nxt = drain - DW'(1);
          end
        end
        default: begin
          // Frozen. Only clear leaves this state.
          state_nxt = S_HALTED;
        end
      endcase
    end
  end

endmodule
